// File: rtl/wb_frame_loader.sv
// ---------------------------------------------------------------------------
// wb_frame_loader
//
// Pipelined Wishbone write master that copies one picture (ROWS words) from a
// combinational picture ROM into the matrix row-register slave at addresses
// 0..ROWS-1. The picture is selected with next/prev/reload button requests.
// Up to MAX_OUTSTANDING writes can be in flight. Each frame ends with a
// one-cycle done pulse, and a sticky error flag reports any err in the frame.
//
// Optional feature: define AUTO_CYCLE_EN to add a free-running counter. Every
// CYCLE_TICKS clocks it raises an internal, lowest-priority "next" request.
// Any user request restarts the counter at 0. Without the macro there is no
// counter logic and CYCLE_TICKS has no effect.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   i_next/i_prev/i_reload  button levels; a rising edge is a request
//   o_pic_num               selected picture index
//   o_busy                  a frame transfer is in progress
//   o_done                  one-cycle pulse after the last ack/err of a frame
//   o_err                   sticky; set by any err in the current frame
//   o_rom_addr, i_rom_data  {pic,row} lookup into the combinational ROM
//   o_wb_*                  Wishbone master outputs (we == stb, sel all ones)
//   i_wb_ack/err/stall      Wishbone slave responses
//   o_dbg_state             current FSM state (IDLE=0, LOAD=1, DRAIN=2)
//
// Handshake: a write is issued in a cycle where o_wb_stb=1 and i_wb_stall=0.
// While stb is high and stall is high, addr and wdata are held. Each issued
// write is terminated by exactly one ack or err in a later cycle.
// ---------------------------------------------------------------------------
module wb_frame_loader #(
    parameter int WB_DATA_WIDTH   = 32,
    parameter int ROWS            = 8,
    parameter int WB_ADDR_WIDTH   = $clog2(ROWS),
    parameter int WB_SEL_WIDTH    = WB_DATA_WIDTH / 8,
    parameter int NUM_PICS        = 4,
    parameter int PIC_W           = $clog2(NUM_PICS),
    parameter int MAX_OUTSTANDING = 4,
    parameter int CYCLE_TICKS     = 50_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_next,
    input  logic                           i_prev,
    input  logic                           i_reload,
    output logic [PIC_W-1:0]               o_pic_num,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic [PIC_W+WB_ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [WB_DATA_WIDTH-1:0]       i_rom_data,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic                           o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0]       o_wb_addr,
    output logic [WB_SEL_WIDTH-1:0]        o_wb_sel,
    output logic [WB_DATA_WIDTH-1:0]       o_wb_wdata,
    input  logic                           i_wb_ack,
    input  logic                           i_wb_err,
    input  logic                           i_wb_stall,
    output logic [1:0]                     o_dbg_state
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PIC_W-1:0]         pic_q, pic_d;
    logic [PIC_W-1:0]         load_pic_q, load_pic_d;
    logic [WB_ADDR_WIDTH-1:0] issue_row_q, issue_row_d;
    logic [OUT_W-1:0]         outst_q, outst_d;
    logic                     pending_q, pending_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     next_q, prev_q, reload_q;

    logic rise_next, rise_prev, rise_reload;
    logic user_req, auto_req, req;
    logic stb_c, issue, resp;

    // Edge detection against the registered copies of the button levels.
    assign rise_next   = i_next   & ~next_q;
    assign rise_prev   = i_prev   & ~prev_q;
    assign rise_reload = i_reload & ~reload_q;
    assign user_req    = rise_next | rise_prev | rise_reload;
    assign req         = user_req | auto_req;

`ifdef AUTO_CYCLE_EN
    localparam int CNT_W = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;

    logic [CNT_W-1:0] tick_q, tick_d;

    always_comb begin
        auto_req = (tick_q == CNT_W'(CYCLE_TICKS - 1));
        tick_d   = tick_q + CNT_W'(1);
        // A user request restarts the period so the picture does not jump
        // shortly after a manual selection.
        if (user_req || auto_req) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end
`else
    assign auto_req = 1'b0;
`endif

    // Picture selection: reload > next > prev > auto-next.
    always_comb begin
        pic_d = pic_q;
        if (rise_reload) begin
            pic_d = pic_q;
        end else if (rise_next || (auto_req && !user_req)) begin
            pic_d = (pic_q == PIC_W'(NUM_PICS - 1)) ? '0 : pic_q + PIC_W'(1);
        end else if (rise_prev) begin
            pic_d = (pic_q == '0) ? PIC_W'(NUM_PICS - 1) : pic_q - PIC_W'(1);
        end
    end

    // Throttle issue so no more than MAX_OUTSTANDING writes are unacked.
    assign stb_c = (state_q == ST_LOAD) && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign issue = stb_c && !i_wb_stall;
    // A termination with nothing outstanding is a stray and is ignored.
    assign resp  = (i_wb_ack || i_wb_err) && (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        if (issue && !resp) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!issue && resp) begin
            outst_d = outst_q - OUT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_row_d = issue_row_q;
        load_pic_d  = load_pic_q;
        pending_d   = pending_q | req;
        err_d       = err_q | (resp & i_wb_err);
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q || req) begin
                    state_d     = ST_LOAD;
                    issue_row_d = '0;
                    err_d       = 1'b0;
                    load_pic_d  = pic_d;
                    pending_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (issue) begin
                    issue_row_d = issue_row_q + WB_ADDR_WIDTH'(1);
                    if (issue_row_q == WB_ADDR_WIDTH'(ROWS - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outst_d == '0) begin
                    done_d = 1'b1;
                    // Requests collected during the frame restart the load
                    // immediately; the picture is latched here so a change
                    // made mid-frame only affects this new frame.
                    if (pending_d) begin
                        state_d     = ST_LOAD;
                        issue_row_d = '0;
                        err_d       = 1'b0;
                        load_pic_d  = pic_d;
                        pending_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pic_q       <= '0;
            load_pic_q  <= '0;
            issue_row_q <= '0;
            outst_q     <= '0;
            // Reload picture 0 as soon as reset is released.
            pending_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            next_q      <= 1'b0;
            prev_q      <= 1'b0;
            reload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pic_q       <= pic_d;
            load_pic_q  <= load_pic_d;
            issue_row_q <= issue_row_d;
            outst_q     <= outst_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
            err_q       <= err_d;
            next_q      <= i_next;
            prev_q      <= i_prev;
            reload_q    <= i_reload;
        end
    end

    // Bus control is gated by reset directly so a reset mid-transfer drops
    // the cycle in the same clock, without waiting for the register update.
    assign o_wb_cyc    = (state_q != ST_IDLE) && !reset;
    assign o_wb_stb    = stb_c && !reset;
    assign o_wb_we     = o_wb_stb;
    assign o_wb_addr   = issue_row_q;
    assign o_wb_sel    = '1;
    assign o_wb_wdata  = i_rom_data;
    assign o_rom_addr  = {load_pic_q, issue_row_q};
    assign o_pic_num   = pic_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wb_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_wb_frame_loader
//
// Bench for wb_frame_loader with ROWS=8, NUM_PICS=4, MAX_OUTSTANDING=4 and
// CYCLE_TICKS=100. The main process drives buttons and pushes the expected
// {addr,data} writes of each frame into exp_q. A separate slave/monitor
// process models the Wishbone slave (stall, ack latency, err injection) and
// pops and compares every accepted write.
// ---------------------------------------------------------------------------
module tb_wb_frame_loader;

  localparam int DW   = 32;
  localparam int ROWS = 8;
  localparam int AW   = 3;
  localparam int SW   = 4;
  localparam int NP   = 4;
  localparam int PW   = 2;
  localparam int MAXO = 4;

  logic          clk;
  logic          reset;
  logic          i_next, i_prev, i_reload;
  logic [PW-1:0] o_pic_num;
  logic          o_busy, o_done, o_err;
  logic [PW+AW-1:0] o_rom_addr;
  logic [DW-1:0] i_rom_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [SW-1:0] o_wb_sel;
  logic [DW-1:0] o_wb_wdata;
  logic          i_wb_ack, i_wb_err, i_wb_stall;
  logic [1:0]    o_dbg_state;

  wb_frame_loader #(
    .WB_DATA_WIDTH  (DW),
    .ROWS           (ROWS),
    .NUM_PICS       (NP),
    .MAX_OUTSTANDING(MAXO),
    .CYCLE_TICKS    (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_next     (i_next),
    .i_prev     (i_prev),
    .i_reload   (i_reload),
    .o_pic_num  (o_pic_num),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_addr  (o_wb_addr),
    .o_wb_sel   (o_wb_sel),
    .o_wb_wdata (o_wb_wdata),
    .i_wb_ack   (i_wb_ack),
    .i_wb_err   (i_wb_err),
    .i_wb_stall (i_wb_stall),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- picture ROM ----------------
  function automatic logic [DW-1:0] rom_word(input logic [PW-1:0] p, input logic [AW-1:0] r);
    return {8'hA5, 6'h00, p, 8'h3C, 5'h00, r};
  endfunction

  assign i_rom_data = rom_word(o_rom_addr[PW+AW-1:AW], o_rom_addr[AW-1:0]);

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- slave model + monitor ----------------
  int lat         = 1;
  int err_row     = -1;
  int stall_row   = -1;
  int stall_limit = 0;
  int stall_used  = 0;
  int cyc_n       = 0;
  int tb_outst    = 0;
  int max_outst   = 0;
  int term_cnt    = 0;
  int done_cnt    = 0;
  int stb_full_viol = 0;
  int stall_viol  = 0;
  int ack_cyc_q[$];
  logic ack_err_q[$];
  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    logic is_err;
    cyc_n++;
    if (reset) begin
      i_wb_ack   = 1'b0;
      i_wb_err   = 1'b0;
      i_wb_stall = 1'b0;
      prev_hold  = 1'b0;
      tb_outst   = 0;
      ack_cyc_q.delete();
      ack_err_q.delete();
      exp_q.delete();
    end else begin
      // Throttle: the DUT must not strobe with MAXO writes outstanding.
      if (o_wb_stb && tb_outst >= MAXO) stb_full_viol++;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      if (ack_cyc_q.size() > 0 && ack_cyc_q[0] == cyc_n) begin
        void'(ack_cyc_q.pop_front());
        is_err = ack_err_q.pop_front();
        if (is_err) i_wb_err = 1'b1;
        else        i_wb_ack = 1'b1;
        tb_outst--;
        term_cnt++;
      end
      i_wb_stall = 1'b0;
      if (o_wb_stb && stall_used < stall_limit && int'(o_wb_addr) == stall_row) begin
        i_wb_stall = 1'b1;
        stall_used++;
      end
      if (prev_hold && (o_wb_addr !== prev_addr || o_wb_wdata !== prev_data)) stall_viol++;
      prev_hold = o_wb_stb && i_wb_stall;
      prev_addr = o_wb_addr;
      prev_data = o_wb_wdata;
      if (o_wb_stb && !i_wb_stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {29'd0, o_wb_addr, o_wb_wdata}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write", {29'd0, o_wb_addr, o_wb_wdata}, {29'd0, e});
        end
        tb_outst++;
        if (tb_outst > max_outst) max_outst = tb_outst;
        ack_cyc_q.push_back(cyc_n + lat);
        ack_err_q.push_back(int'(o_wb_addr) == err_row);
      end
      if (o_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_frame(input int p);
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({AW'(r), rom_word(PW'(p), AW'(r))});
    end
  endtask

  task automatic pulse(input int which);
    step();
    if (which == 0) i_next = 1'b1;
    else if (which == 1) i_prev = 1'b1;
    else i_reload = 1'b1;
    step();
    step();
    i_next   = 1'b0;
    i_prev   = 1'b0;
    i_reload = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step();
    while ((o_busy || exp_q.size() != 0 || tb_outst != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("timeout_idle", 64'd0, 64'd1);
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  int d0, t0, s0;
  int pic_model;
  int n;

  initial begin
    reset    = 1'b1;
    i_next   = 1'b0;
    i_prev   = 1'b0;
    i_reload = 1'b0;
    pic_model = 0;
    step(); step(); step();

    // 1: reset state, then automatic load of picture 0 with ack latency 1
    check("rst_cyc",  {63'd0, o_wb_cyc},  64'd0);
    check("rst_stb",  {63'd0, o_wb_stb},  64'd0);
    check("rst_busy", {63'd0, o_busy},    64'd0);
    check("rst_done", {63'd0, o_done},    64'd0);
    check("rst_err",  {63'd0, o_err},     64'd0);
    check("rst_pic",  {62'd0, o_pic_num}, 64'd0);
    d0 = done_cnt; t0 = term_cnt;
    push_frame(0);
    reset = 1'b0;
    wait_idle(100);
    check("t1_done", 64'(done_cnt - d0), 64'd1);
    check("t1_terms", 64'(term_cnt - t0), 64'd8);
    check("t1_busy", {63'd0, o_busy}, 64'd0);
    check("t1_pic", {62'd0, o_pic_num}, 64'd0);

`ifdef AUTO_CYCLE_EN
    // 7: auto-advance every 100 cycles, wrapping 3 -> 0
    begin
      int chg[$];
      int last_pic;
      push_frame(1); push_frame(2); push_frame(3); push_frame(0);
      last_pic = int'(o_pic_num);
      d0 = done_cnt;
      for (int i = 0; i < 460; i++) begin
        step();
        if (int'(o_pic_num) != last_pic) begin
          chg.push_back(cyc_n);
          last_pic = int'(o_pic_num);
        end
      end
      check("t7_changes", 64'(chg.size()), 64'd4);
      for (int i = 1; i < chg.size(); i++) check("t7_period", 64'(chg[i] - chg[i-1]), 64'd100);
      check("t7_pic", {62'd0, o_pic_num}, 64'd0);
      check("t7_frames_left", 64'(exp_q.size()), 64'd0);
      check("t7_done", 64'(done_cnt - d0), 64'd4);
    end
`else
    // 2: stall row 2 for 3 cycles with ack latency 5, then latency 8 to hit the limit
    lat = 5; stall_row = 2; stall_limit = stall_used + 3; s0 = stall_used;
    d0 = done_cnt; t0 = term_cnt;
    push_frame(0);
    pulse(2);
    wait_idle(200);
    check("t2_stalls", 64'(stall_used - s0), 64'd3);
    check("t2_terms", 64'(term_cnt - t0), 64'd8);
    check("t2_done", 64'(done_cnt - d0), 64'd1);
    lat = 8; stall_row = -1;
    d0 = done_cnt;
    push_frame(0);
    pulse(2);
    wait_idle(200);
    check("t2_done_b", 64'(done_cnt - d0), 64'd1);
    check("t2_max_outst", 64'(max_outst), 64'(MAXO));
    check("t2_stb_at_max", 64'(stb_full_viol), 64'd0);
    check("t2_stall_stable", 64'(stall_viol), 64'd0);

    // 3: prev wraps 0 -> 3, next wraps 3 -> 0, prev back to 3
    lat = 1;
    push_frame(3);
    step();
    i_prev = 1'b1;
    step();
    check("t3_pic_update", {62'd0, o_pic_num}, 64'd3);
    i_prev = 1'b0;
    wait_idle(100);
    push_frame(0);
    pulse(0);
    wait_idle(100);
    check("t3_pic_next", {62'd0, o_pic_num}, 64'd0);
    push_frame(3);
    pulse(1);
    wait_idle(100);
    check("t3_pic_prev", {62'd0, o_pic_num}, 64'd3);

    // 4: next and prev during a frame: old picture finishes, one extra frame
    lat = 8;
    d0 = done_cnt; t0 = term_cnt;
    push_frame(3); push_frame(3);
    pulse(2);
    step(); step();
    check("t4_busy", {63'd0, o_busy}, 64'd1);
    pulse(0);
    pulse(1);
    check("t4_still_busy", {63'd0, o_busy}, 64'd1);
    wait_idle(300);
    check("t4_done", 64'(done_cnt - d0), 64'd2);
    check("t4_terms", 64'(term_cnt - t0), 64'd16);
    check("t4_pic", {62'd0, o_pic_num}, 64'd3);

    // 5: err on row 5 terminates that write and sets the sticky flag
    lat = 2; err_row = 5;
    d0 = done_cnt; t0 = term_cnt;
    push_frame(3);
    pulse(2);
    wait_idle(100);
    check("t5_terms", 64'(term_cnt - t0), 64'd8);
    check("t5_done", 64'(done_cnt - d0), 64'd1);
    check("t5_err", {63'd0, o_err}, 64'd1);
    step(); step(); step();
    check("t5_err_sticky", {63'd0, o_err}, 64'd1);
    err_row = -1;
    push_frame(3);
    step();
    i_reload = 1'b1;
    step();
    check("t5_err_clear", {63'd0, o_err}, 64'd0);
    check("t5_reload_busy", {63'd0, o_busy}, 64'd1);
    i_reload = 1'b0;
    wait_idle(100);
    check("t5_err_after", {63'd0, o_err}, 64'd0);

    // 6: reset with 3 writes outstanding, then picture 0 reloads
    lat = 20;
    push_frame(3);
    step();
    i_reload = 1'b1;
    n = 0;
    while (tb_outst != 3 && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) check("t6_timeout_outst", 64'(tb_outst), 64'd3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_cyc_drop", {63'd0, o_wb_cyc}, 64'd0);
    check("t6_stb_drop", {63'd0, o_wb_stb}, 64'd0);
    i_reload = 1'b0;
    step(); step(); step();
    check("t6_rst_pic", {62'd0, o_pic_num}, 64'd0);
    lat = 1;
    d0 = done_cnt;
    push_frame(0);
    reset = 1'b0;
    wait_idle(100);
    check("t6_done", 64'(done_cnt - d0), 64'd1);
    check("t6_pic", {62'd0, o_pic_num}, 64'd0);
    check("t6_busy", {63'd0, o_busy}, 64'd0);
`endif

    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
